// File: rtl/core_io_peripheral_if.sv
// Bundle of the core-side and host-side handshake signals of the I/O endpoint.
// The slave modport is the peripheral's view. The master modport is the view of
// the environment that drives the core and host ports.
interface core_io_peripheral_if #(
  parameter int DATA_WIDTH = 32
);
  // Valid/ready semantics on both host ports: a word moves on a rising clock
  // edge where valid and ready are both high. Valid must not depend
  // combinationally on ready. The core-side ports are unacknowledged
  // single-cycle pulses.
  logic [1:0]            core_to_peripheral;
  logic [DATA_WIDTH-1:0] core_to_peripheral_data;
  logic                  core_to_peripheral_valid;
  logic [1:0]            core_from_peripheral;
  logic [DATA_WIDTH-1:0] core_from_peripheral_data;
  logic                  core_from_peripheral_valid;
  logic                  host_rd_valid;
  logic                  host_rd_ready;
  logic [1:0]            host_rd_code;
  logic [DATA_WIDTH-1:0] host_rd_data;
  logic                  host_wr_valid;
  logic                  host_wr_ready;
  logic [1:0]            host_wr_code;
  logic [DATA_WIDTH-1:0] host_wr_data;

  modport slave (
    input  core_to_peripheral, core_to_peripheral_data, core_to_peripheral_valid,
    output core_from_peripheral, core_from_peripheral_data, core_from_peripheral_valid,
    output host_rd_valid, host_rd_code, host_rd_data,
    input  host_rd_ready,
    input  host_wr_valid, host_wr_code, host_wr_data,
    output host_wr_ready
  );

  modport master (
    output core_to_peripheral, core_to_peripheral_data, core_to_peripheral_valid,
    input  core_from_peripheral, core_from_peripheral_data, core_from_peripheral_valid,
    input  host_rd_valid, host_rd_code, host_rd_data,
    output host_rd_ready,
    output host_wr_valid, host_wr_code, host_wr_data,
    input  host_wr_ready
  );
endinterface

// File: rtl/core_io_peripheral.sv
// Peripheral endpoint beside a RISC-V core.
// Core results are buffered in a first-word-fall-through FIFO that the host
// drains. Host words are presented to the core as spaced single-cycle pulses.
module core_io_peripheral #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_ADDR_BITS = 3,
  parameter int MIN_GAP        = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  core_io_peripheral_if.slave     bus,
  output logic [FIFO_ADDR_BITS:0] fifo_count,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  input  logic                    clear_overflow,
  output logic [1:0]              fsm_state
);

  localparam int EW    = DATA_WIDTH + 2;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [FIFO_ADDR_BITS:0]   FULL_CNT = (FIFO_ADDR_BITS + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_ADDR_BITS:0]   CNT_ONE  = (FIFO_ADDR_BITS + 1)'(1);
  localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE  = FIFO_ADDR_BITS'(1);
  localparam logic [GAP_W-1:0]          GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0]          GAP_ONE  = GAP_W'(1);

  // ---------------- result FIFO (core -> host) ----------------
  logic [EW-1:0]             mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_BITS:0]   count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic [7:0]                drop_q, drop_d;
  logic                      empty, full, pop, push_ok, drop;

  // Pop is evaluated first so a full FIFO that is popping still accepts a push.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    pop     = !empty && bus.host_rd_ready;
    push_ok = bus.core_to_peripheral_valid && (!full || pop);
    drop    = bus.core_to_peripheral_valid && full && !pop;
  end

  // Next occupancy and drop bookkeeping. A drop beats a same-cycle clear.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (push_ok && !pop)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop) count_d = count_q - CNT_ONE;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow)      drop_d = 8'd1;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
  end

  // Storage write; the contents need no reset because the outputs are gated by occupancy.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= {bus.core_to_peripheral, bus.core_to_peripheral_data};
  end

  // Pointers, occupancy and overflow status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // The head entry is shown directly from storage and forced to zero while empty.
  always_comb begin
    bus.host_rd_valid = !empty;
    bus.host_rd_code  = empty ? 2'b00 : mem_q[rd_ptr_q][EW-1 -: 2];
    bus.host_rd_data  = empty ? '0 : mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    fifo_count        = count_q;
    overflow          = overflow_q;
    drop_count        = drop_q;
  end

  // ---------------- core-bound pulse FSM (host -> core) ----------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  state_t                state_q;
  logic [GAP_W-1:0]      gap_q;
  logic                  cvalid_q;
  logic                  wready_q;
  logic [1:0]            ccode_q;
  logic [DATA_WIDTH-1:0] cdata_q;

  // The GAP state lasts MIN_GAP cycles, which spaces pulse starts by MIN_GAP+2 cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      cvalid_q <= 1'b0;
      wready_q <= 1'b1;
      ccode_q  <= 2'b00;
      cdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.host_wr_valid) begin
            ccode_q  <= bus.host_wr_code;
            cdata_q  <= bus.host_wr_data;
            cvalid_q <= 1'b1;
            wready_q <= 1'b0;
            state_q  <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          cvalid_q <= 1'b0;
          gap_q    <= GAP_LOAD;
          state_q  <= S_GAP;
        end
        S_GAP: begin
          if (gap_q == '0) begin
            wready_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            gap_q <= gap_q - GAP_ONE;
          end
        end
        default: begin
          cvalid_q <= 1'b0;
          wready_q <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  // Core-bound outputs come straight from registers, so reset clears the pulse at once.
  always_comb begin
    bus.core_from_peripheral       = ccode_q;
    bus.core_from_peripheral_data  = cdata_q;
    bus.core_from_peripheral_valid = cvalid_q;
    bus.host_wr_ready              = wready_q;
    fsm_state                      = state_q;
  end

endmodule

// File: tb/tb_core_io_peripheral.sv
// Directed bench for core_io_peripheral: a result FIFO scoreboard and a core-pulse scoreboard.
module tb_core_io_peripheral;

  localparam int DW = 32;

  logic       clock;
  logic       reset;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clear_overflow;
  logic [1:0] fsm_state;

  core_io_peripheral_if #(.DATA_WIDTH(DW)) bus ();

  core_io_peripheral #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(8), .FIFO_ADDR_BITS(3), .MIN_GAP(2)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
    .clear_overflow(clear_overflow), .fsm_state(fsm_state)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] core_exp_q[$];

  // ---------------- clock/reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One core result pulse; expected in the FIFO only when accept is set.
  task automatic drive_core(input logic [1:0] code, input logic [DW-1:0] data, input bit accept);
    bus.core_to_peripheral_valid = 1'b1;
    bus.core_to_peripheral       = code;
    bus.core_to_peripheral_data  = data;
    if (accept) exp_q.push_back({code, data});
    tick();
    bus.core_to_peripheral_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.host_rd_ready = 1'b1;
    repeat (n) tick();
    bus.host_rd_ready = 1'b0;
  endtask

  // ---------------- monitors ----------------
  // Host read side: every handshake pops the next expected entry.
  always @(negedge clock) begin
    if (!reset && bus.host_rd_valid && bus.host_rd_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_pop unexpected word got=%0h", {bus.host_rd_code, bus.host_rd_data});
      end else begin
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        if ({bus.host_rd_code, bus.host_rd_data} !== e) begin
          fails++;
          $display("FAIL rd_pop got=%0h expected=%0h", {bus.host_rd_code, bus.host_rd_data}, e);
        end
      end
    end
  end

  // Core side: each pulse matches the expected word, lasts one cycle, and is spaced >= 4 cycles.
  bit prev_v    = 1'b0;
  int last_cyc  = -100;
  always @(negedge clock) begin
    if (reset) begin
      prev_v   = 1'b0;
      last_cyc = -100;
    end else begin
      if (bus.core_from_peripheral_valid) begin
        tests++;
        if (core_exp_q.size() == 0) begin
          fails++;
          $display("FAIL core_pulse unexpected got=%0h", bus.core_from_peripheral_data);
        end else begin
          logic [DW+1:0] e;
          e = core_exp_q.pop_front();
          if ({bus.core_from_peripheral, bus.core_from_peripheral_data} !== e) begin
            fails++;
            $display("FAIL core_pulse got=%0h expected=%0h",
                     {bus.core_from_peripheral, bus.core_from_peripheral_data}, e);
          end
        end
        tests++;
        if (prev_v || (cyc - last_cyc) < 4) begin
          fails++;
          $display("FAIL core_pulse_shape width_ok=%0d spacing got=%0d expected>=4", !prev_v, cyc - last_cyc);
        end
        last_cyc = cyc;
      end
      prev_v = bus.core_from_peripheral_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ev [5];
    bit er [5];
    reset = 1'b1;
    clear_overflow = 1'b0;
    bus.core_to_peripheral = 2'b00;
    bus.core_to_peripheral_data = '0;
    bus.core_to_peripheral_valid = 1'b0;
    bus.host_rd_ready = 1'b0;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_code = 2'b00;
    bus.host_wr_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // reset values
    chk("rst_rd_valid", 64'(bus.host_rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.host_rd_data), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_core_valid", 64'(bus.core_from_peripheral_valid), 64'd0);
    chk("rst_core_data", 64'(bus.core_from_peripheral_data), 64'd0);
    chk("rst_wr_ready", 64'(bus.host_wr_ready), 64'd1);

    // 1: single word, one-cycle latency, later popped
    drive_core(2'd0, 32'h0000002A, 1'b1);
    chk("t1_valid", 64'(bus.host_rd_valid), 64'd1);
    chk("t1_data", 64'(bus.host_rd_data), 64'h2A);
    chk("t1_count", 64'(fifo_count), 64'd1);
    tick();
    chk("t1_hold", 64'(bus.host_rd_data), 64'h2A);
    drain(1);
    chk("t1_count_after", 64'(fifo_count), 64'd0);
    chk("t1_valid_after", 64'(bus.host_rd_valid), 64'd0);

    // 2: fill, overflow by one, drain in order
    for (int i = 1; i <= 8; i++) drive_core(2'd3, 32'(i), 1'b1);
    chk("t2_full_count", 64'(fifo_count), 64'd8);
    chk("t2_no_ovf_yet", 64'(overflow), 64'd0);
    drive_core(2'd3, 32'd9, 1'b0);
    chk("t2_count", 64'(fifo_count), 64'd8);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_drop", 64'(drop_count), 64'd1);
    drain(8);
    chk("t2_drained", 64'(fifo_count), 64'd0);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // clear overflow alone
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_count), 64'd0);

    // 3: full FIFO, simultaneous pop and push
    for (int i = 0; i < 8; i++) drive_core(2'd1, 32'h30 + 32'(i), 1'b1);
    bus.host_rd_ready = 1'b1;
    drive_core(2'd2, 32'hAA, 1'b1);
    bus.host_rd_ready = 1'b0;
    chk("t3_count", 64'(fifo_count), 64'd8);
    chk("t3_overflow", 64'(overflow), 64'd0);
    drain(8);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: drop saturation, then clear colliding with a drop
    for (int i = 0; i < 8; i++) drive_core(2'd0, 32'h100 + 32'(i), 1'b1);
    for (int i = 0; i < 300; i++) drive_core(2'd0, 32'hDEAD0000 + 32'(i), 1'b0);
    chk("t4_drop_sat", 64'(drop_count), 64'd255);
    chk("t4_overflow", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    drive_core(2'd0, 32'hBEEF, 1'b0);
    clear_overflow = 1'b0;
    chk("t4_clr_drop_ovf", 64'(overflow), 64'd1);
    chk("t4_clr_drop_cnt", 64'(drop_count), 64'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("t4_clr_ovf", 64'(overflow), 64'd0);
    drain(8);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5: back-to-back host words, pulse timing and spacing
    ev[0] = 1; ev[1] = 0; ev[2] = 0; ev[3] = 0; ev[4] = 1;
    er[0] = 0; er[1] = 0; er[2] = 0; er[3] = 1; er[4] = 0;
    chk("t5_ready_idle", 64'(bus.host_wr_ready), 64'd1);
    bus.host_wr_valid = 1'b1;
    bus.host_wr_code  = 2'd1;
    bus.host_wr_data  = 32'h11;
    core_exp_q.push_back({2'd1, 32'h11});
    tick();
    bus.host_wr_code = 2'd2;
    bus.host_wr_data = 32'h22;
    core_exp_q.push_back({2'd2, 32'h22});
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_valid_c%0d", i + 1), 64'(bus.core_from_peripheral_valid), 64'(ev[i]));
      chk($sformatf("t5_ready_c%0d", i + 1), 64'(bus.host_wr_ready), 64'(er[i]));
      if (i == 4) bus.host_wr_valid = 1'b0;
      tick();
    end
    chk("t5_hold_data", 64'(bus.core_from_peripheral_data), 64'h22);
    chk("t5_hold_code", 64'(bus.core_from_peripheral), 64'd2);
    repeat (4) tick();
    chk("t5_core_queue_empty", 64'(core_exp_q.size()), 64'd0);

    // 6: asynchronous reset during PRESENT with FIFO entries
    for (int i = 0; i < 3; i++) drive_core(2'd0, 32'h500 + 32'(i), 1'b1);
    bus.host_wr_valid = 1'b1;
    bus.host_wr_code  = 2'd3;
    bus.host_wr_data  = 32'h55;
    tick();
    bus.host_wr_valid = 1'b0;
    chk("t6_present", 64'(bus.core_from_peripheral_valid), 64'd1);
    chk("t6_count_before", 64'(fifo_count), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid_dropped", 64'(bus.core_from_peripheral_valid), 64'd0);
    chk("t6_count_async", 64'(fifo_count), 64'd0);
    exp_q.delete();
    core_exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("t6_count", 64'(fifo_count), 64'd0);
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_wr_ready", 64'(bus.host_wr_ready), 64'd1);
    chk("t6_rd_valid", 64'(bus.host_rd_valid), 64'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_io_peripheral.md
Name: core_io_peripheral

Overview:
- Peripheral-side endpoint of the core's to_peripheral/from_peripheral I/O interface.
- Captures result words the core emits on writeback to a0-a7 (x10-x17) into a FIFO and hands them to a host over a valid/ready port.
- In the other direction, accepts host words and presents each to the core as a spaced, single-cycle from_peripheral pulse.
- Sits beside each RISC_V_Core instance in the multi-core top level.

Parameters:
DATA_WIDTH, 32, width of the data word in both directions
FIFO_DEPTH, 8, result FIFO entries (power of two)
FIFO_ADDR_BITS, 3, log2(FIFO_DEPTH)
MIN_GAP, 2, minimum idle cycles between consecutive core-bound pulses (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
core_to_peripheral  input  2  code field from core
core_to_peripheral_data  input  DATA_WIDTH  result word from core
core_to_peripheral_valid  input  1  one-cycle pulse per result; cannot be back-pressured
core_from_peripheral  output  2  code field to core
core_from_peripheral_data  output  DATA_WIDTH  word to core
core_from_peripheral_valid  output  1  one-cycle pulse to core
host_rd_valid  output  1  FIFO head valid
host_rd_ready  input  1  host consumes head when valid&ready
host_rd_code  output  2  code stored with head entry
host_rd_data  output  DATA_WIDTH  head data
host_wr_valid  input  1  host offers word for core
host_wr_ready  output  1  block accepts host word
host_wr_code  input  2  code for core-bound word
host_wr_data  input  DATA_WIDTH  core-bound word
fifo_count  output  FIFO_ADDR_BITS+1  current occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky: a core result was dropped
drop_count  output  8  dropped results, saturates at 255
clear_overflow  input  1  clears overflow and drop_count

Behaviour:
- Clock and reset: single clock (clock); reset is asynchronous, active-high.
- Reset values: every output is 0. Exception: host_wr_ready=1.
- Reset asserted mid-operation: clears the FIFO, counters and FSM immediately. An in-flight core pulse is aborted, and core_from_peripheral_valid goes low without waiting for a clock edge.

Result FIFO (core -> host):
- Entry format: {code[1:0], data}.
- Push: core_to_peripheral_valid.
- Pop: host_rd_valid & host_rd_ready.
- Registered, first-word-fall-through. A word pushed at edge N appears on host_rd_* after edge N (1-cycle latency), including when the FIFO was empty.
- host_rd_valid = (fifo_count != 0).
- host_rd_data and host_rd_code hold stable while valid & !ready.
- Push and pop in the same cycle:
  - When not empty: both happen, count unchanged.
  - When full: both happen; the pop frees space first, so the push is never dropped.
  - When empty: the push is stored, and the pop does nothing since valid=0.
- Push while full with no pop:
  - Word is discarded.
  - overflow<=1.
  - drop_count increments, saturating at 255.
  - FIFO contents are untouched.
- clear_overflow: overflow<=0, drop_count<=0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH and never wraps.

Core-bound FSM (host -> core), states IDLE, PRESENT, GAP:
- IDLE:
  - host_wr_ready=1.
  - When host_wr_valid: latch code and data, go to PRESENT.
- PRESENT:
  - core_from_peripheral_valid=1 for exactly this cycle; host_wr_ready=0.
  - Go to GAP and load gap counter = MIN_GAP-1.
- GAP:
  - host_wr_ready=0, valid=0.
  - Counter decrements each cycle; when it reaches 0, go to IDLE.
- Pulse timing: the host handshake at edge N produces the valid pulse in the cycle after edge N.
- Pulse spacing: the minimum spacing between pulse rising edges is MIN_GAP+2 cycles.
- core_from_peripheral and core_from_peripheral_data hold the last latched value after the pulse; they are 0 only after reset.
- The two directions are fully independent; simultaneous activity on both never interacts.

Test Plan:
1. Reset, then pulse core valid with code=0, data=0x0000002A at edge 5 -> host_rd_valid=1, data=0x2A, fifo_count=1 from cycle 6; ready=1 at cycle 8 pops it -> count=0, valid=0 at cycle 9.
2. Push 8 words 1..8 with host_rd_ready=0, then push 9 -> count=8, overflow=1, drop_count=1; draining returns 1..8 in order, and 9 never appears.
3. FIFO full and host_rd_ready=1 while core pushes 0xAA -> pop and push in the same cycle, count stays 8, overflow stays 0, and 0xAA is the last word drained.
4. Drop 300 words into a full FIFO -> drop_count=255 (saturated); clear_overflow together with one more drop -> overflow=1, drop_count=1.
5. With MIN_GAP=2, host holds wr_valid with data 0x11 then 0x22 back-to-back -> pulses in cycles t+1 and t+5, each exactly 1 cycle, carrying 0x11 then 0x22; host_wr_ready low for cycles t+1..t+3.
6. Assert reset asynchronously during PRESENT with 3 FIFO entries -> core_from_peripheral_valid drops immediately; count=0, overflow=0, host_wr_ready=1 after release.
